ebr_fifo_sync: RTL and testbench
================================

Name: ebr_fifo_sync

Overview:
- Parametrised single-clock FIFO built on a synchronous-read block-RAM array, inferable onto one or more cascaded EBR / SB_RAM40_4K primitives.
- Generalises the fixed 4 kbit, 2/4/8/16-bit RAM cell to arbitrary width and depth.
- Adds pointer management, first-word-fall-through output, programmable almost-flags, occupancy count and sticky error flags.
- Sits between a producer and a consumer in the iCE40 fabric as the standard buffering block for streaming datapaths.

Parameters:
- DATA_WIDTH, 16, bits per word (1..64).
- ADDR_WIDTH, 8, log2 of depth; DEPTH = 2**ADDR_WIDTH total words, output register included (2..12).
- AF_THRESH, 2**ADDR_WIDTH-4, ALMOST_FULL asserts when COUNT >= AF_THRESH.
- AE_THRESH, 4, ALMOST_EMPTY asserts when COUNT <= AE_THRESH.

Ports:
- CLK  input  1  single clock; all logic on the rising edge.
- RST  input  1  synchronous reset, active-high.
- WE  input  1  write request.
- WDATA  input  DATA_WIDTH  write data, sampled when WE && !FULL.
- FULL  output  1  COUNT == DEPTH.
- ALMOST_FULL  output  1  COUNT >= AF_THRESH.
- RE  input  1  read/pop request; pops RDATA when RE && !EMPTY.
- RDATA  output  DATA_WIDTH  head word; valid whenever EMPTY == 0 (FWFT).
- EMPTY  output  1  no valid word in the output register.
- ALMOST_EMPTY  output  1  COUNT <= AE_THRESH.
- COUNT  output  ADDR_WIDTH+1  words held, output register included.
- OVERFLOW  output  1  sticky: a write was attempted while FULL.
- UNDERFLOW  output  1  sticky: a read was attempted while EMPTY.

Behaviour:
- Interface: one clock and one reset only. CLK is the single clock. RST is synchronous and active-high.
- Reset (RST high at a rising edge):
  - wr_ptr = rd_ptr = 0; COUNT = 0.
  - EMPTY = 1, ALMOST_EMPTY = 1, FULL = 0, ALMOST_FULL = 0.
  - RDATA = 0, OVERFLOW = 0, UNDERFLOW = 0.
  - Memory contents are not cleared.
  - RST overrides WE/RE in the same cycle; reset mid-stream discards all data.
- Accept rules:
  - wr_acc = WE && !FULL. A write while FULL is dropped and sets OVERFLOW, even if RE is asserted in the same cycle. FULL gates writes strictly; no pass-through.
  - rd_acc = RE && !EMPTY. A read while EMPTY is ignored and sets UNDERFLOW.
- Storage: memory written at wr_ptr on wr_acc, then wr_ptr increments mod DEPTH. Read port is synchronous: one-cycle address-to-data, matching EBR timing.
- Prefetch:
  - An internal valid bit on the output register: EMPTY = !valid.
  - When the output register is empty or being popped, and the memory holds unread words, issue a memory read at rd_ptr; rd_ptr increments.
  - Returned data loads RDATA on the following edge.
- Latency:
  - Write into an empty FIFO in cycle k: EMPTY falls in cycle k+2 with RDATA = that word.
  - Back-to-back pops of a non-empty FIFO give one new word per cycle, no bubbles, once the memory holds >= 2 words.
- COUNT:
  - +1 on wr_acc only, -1 on rd_acc only, unchanged when both occur or neither occurs.
  - Updates the cycle after the accept, so COUNT may read 1 while EMPTY is still 1 (latency window). This is legal.
- Flags:
  - FULL, ALMOST_FULL and ALMOST_EMPTY are registered and consistent with the registered COUNT in the same cycle.
  - EMPTY derives from the output register valid bit only.
- Wrap-around: pointers are ADDR_WIDTH bits and wrap DEPTH-1 -> 0 transparently. Ordering is strict FIFO across the wrap.
- Simultaneous WE and RE with 0 < COUNT < DEPTH: both accepted; COUNT unchanged.
- OVERFLOW and UNDERFLOW clear only on RST.

Test Plan:
- Reset then idle 5 cycles -> EMPTY=1, ALMOST_EMPTY=1, FULL=0, COUNT=0, RDATA=0, OVERFLOW=0, UNDERFLOW=0.
- Single write of 16'hA5A5 at cycle k (DATA_WIDTH=16, ADDR_WIDTH=8) -> EMPTY=0 and RDATA=16'hA5A5 at cycle k+2; COUNT=1 from k+1; RE at k+2 -> EMPTY=1, COUNT=0 at k+3.
- Write 256 words 0..255 without reads -> FULL=1 at COUNT=256, ALMOST_FULL from COUNT=252; a 257th write with RE also high -> word dropped, OVERFLOW=1, COUNT=255 after the pop.
- Fill 200 words, then hold WE and RE high for 600 cycles with an incrementing pattern -> COUNT stays 200, pointers wrap at least twice, output sequence contiguous with no gaps or duplicates.
- RE on an empty FIFO -> UNDERFLOW=1 sticky, COUNT stays 0; ALMOST_EMPTY deasserts only when COUNT reaches 5 during refill.
- Assert RST mid-stream with COUNT=37 and WE=RE=1 -> next cycle COUNT=0, EMPTY=1, flags cleared; subsequent write of 16'h0001 reads back 16'h0001, with no stale data.

Source files
------------

// File: rtl/ebr_fifo_sync.sv
// Single-clock first-word-fall-through FIFO on a synchronous-read RAM array.
// It has almost-full and almost-empty flags, an occupancy count and sticky error flags.
//
// Ports:
//   CLK, RST         clock and synchronous active-high reset
//   WE, WDATA, FULL  write side; ALMOST_FULL when COUNT >= AF_THRESH
//   RE, RDATA, EMPTY read side (FWFT); ALMOST_EMPTY when COUNT <= AE_THRESH
//   COUNT            words held, output register included
//   OVERFLOW         sticky: write attempted while FULL
//   UNDERFLOW        sticky: read attempted while EMPTY
module ebr_fifo_sync #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8,
  parameter int AF_THRESH  = 2**ADDR_WIDTH - 4,
  parameter int AE_THRESH  = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  WE,
  input  logic [DATA_WIDTH-1:0] WDATA,
  output logic                  FULL,
  output logic                  ALMOST_FULL,
  input  logic                  RE,
  output logic [DATA_WIDTH-1:0] RDATA,
  output logic                  EMPTY,
  output logic                  ALMOST_EMPTY,
  output logic [ADDR_WIDTH:0]   COUNT,
  output logic                  OVERFLOW,
  output logic                  UNDERFLOW
);

  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_C =
    (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_C =
    (ADDR_WIDTH+1)'(AF_THRESH);
  localparam logic [ADDR_WIDTH:0] AE_C =
    (ADDR_WIDTH+1)'(AE_THRESH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic                  valid;
  logic                  wr_acc;
  logic                  rd_acc;
  logic                  avail;
  logic                  rd_issue;
  logic [ADDR_WIDTH:0]   cnt_nxt;

  assign EMPTY = !valid;

  // The RAM read register is the output register, so COUNT minus
  // the valid bit is the number of words still unread in the array.
  always_comb begin
    wr_acc   = WE && !FULL;
    rd_acc   = RE && valid;
    avail    = COUNT != {{ADDR_WIDTH{1'b0}}, valid};
    rd_issue = avail && (!valid || rd_acc);
    cnt_nxt  = COUNT;
    if (wr_acc && !rd_acc)
      cnt_nxt = COUNT + 1'b1;
    else if (rd_acc && !wr_acc)
      cnt_nxt = COUNT - 1'b1;
  end

  // A prefetch never targets the slot being written: it needs an
  // unread word, so rd_ptr != wr_ptr whenever the array is not full.
  always_ff @(posedge CLK) begin
    if (wr_acc && !RST)
      mem[wr_ptr] <= WDATA;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      valid        <= 1'b0;
      RDATA        <= '0;
      COUNT        <= '0;
      FULL         <= 1'b0;
      ALMOST_FULL  <= 1'b0;
      ALMOST_EMPTY <= 1'b1;
      OVERFLOW     <= 1'b0;
      UNDERFLOW    <= 1'b0;
    end else begin
      if (wr_acc)
        wr_ptr <= wr_ptr + 1'b1;
      if (rd_issue) begin
        RDATA  <= mem[rd_ptr];
        rd_ptr <= rd_ptr + 1'b1;
        valid  <= 1'b1;
      end else if (rd_acc) begin
        valid  <= 1'b0;
      end
      COUNT        <= cnt_nxt;
      FULL         <= cnt_nxt == DEPTH_C;
      ALMOST_FULL  <= cnt_nxt >= AF_C;
      ALMOST_EMPTY <= cnt_nxt <= AE_C;
      if (WE && FULL)
        OVERFLOW <= 1'b1;
      if (RE && !valid)
        UNDERFLOW <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ebr_fifo_sync.sv
// Scoreboard bench for ebr_fifo_sync with default parameters.
// Directed stimulus feeds a queue; a negedge monitor checks pops and flags.
module tb_ebr_fifo_sync;

  localparam int DW    = 16;
  localparam int AW    = 8;
  localparam int DEPTH = 256;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          WE  = 1'b0;
  logic [DW-1:0] WDATA = '0;
  logic          RE  = 1'b0;
  logic          FULL, ALMOST_FULL;
  logic [DW-1:0] RDATA;
  logic          EMPTY, ALMOST_EMPTY;
  logic [AW:0]   COUNT;
  logic          OVERFLOW, UNDERFLOW;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] sb [$];
  int            mcnt = 0;
  logic          movf = 1'b0;
  logic          munf = 1'b0;

  ebr_fifo_sync dut (
    .CLK(CLK), .RST(RST),
    .WE(WE), .WDATA(WDATA),
    .FULL(FULL), .ALMOST_FULL(ALMOST_FULL),
    .RE(RE), .RDATA(RDATA),
    .EMPTY(EMPTY), .ALMOST_EMPTY(ALMOST_EMPTY),
    .COUNT(COUNT),
    .OVERFLOW(OVERFLOW), .UNDERFLOW(UNDERFLOW)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 30)
        $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Monitor: inputs are stable by the negedge, so it decides here
  // what the coming edge accepts, and checks registered state.
  always @(negedge CLK) begin
    logic [DW-1:0] e;
    check("count", 32'(COUNT), 32'(mcnt));
    check("full", 32'(FULL), 32'(mcnt == DEPTH));
    check("afull", 32'(ALMOST_FULL), 32'(mcnt >= DEPTH - 4));
    check("aempty", 32'(ALMOST_EMPTY), 32'(mcnt <= 4));
    check("ovf", 32'(OVERFLOW), 32'(movf));
    check("unf", 32'(UNDERFLOW), 32'(munf));
    if (mcnt == 0)
      check("empty_at_0", 32'(EMPTY), 32'd1);
    if (RST) begin
      sb.delete();
      mcnt = 0;
      movf = 1'b0;
      munf = 1'b0;
    end else begin
      if (RE && !EMPTY) begin
        if (sb.size() == 0) begin
          check("pop_on_empty_sb", 32'(RDATA), 32'hdead);
        end else begin
          e = sb.pop_front();
          check("rdata", 32'(RDATA), 32'(e));
        end
        mcnt--;
      end
      if (RE && EMPTY)
        munf = 1'b1;
      if (WE && mcnt + (RE && !EMPTY ? 1 : 0) < DEPTH) begin
        sb.push_back(WDATA);
        mcnt++;
      end else if (WE) begin
        movf = 1'b1;
      end
    end
  end

  task automatic do_reset();
    RST = 1'b1; WE = 1'b0; RE = 1'b0;
    tick();
    RST = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    RE = 1'b1; WE = 1'b0;
    while ((!EMPTY || COUNT != 0) && n < 2000) begin
      tick();
      n++;
    end
    RE = 1'b0;
    check("drain_timeout", 32'(n < 2000), 32'd1);
  endtask

  initial begin
    // reset and idle
    do_reset();
    repeat (5) tick();
    check("rst_empty", 32'(EMPTY), 32'd1);
    check("rst_aempty", 32'(ALMOST_EMPTY), 32'd1);
    check("rst_full", 32'(FULL), 32'd0);
    check("rst_count", 32'(COUNT), 32'd0);
    check("rst_rdata", 32'(RDATA), 32'd0);
    check("rst_ovf", 32'(OVERFLOW), 32'd0);
    check("rst_unf", 32'(UNDERFLOW), 32'd0);

    // single write latency
    WE = 1'b1; WDATA = 16'hA5A5;
    tick();
    WE = 1'b0;
    check("k1_count", 32'(COUNT), 32'd1);
    check("k1_empty", 32'(EMPTY), 32'd1);
    tick();
    check("k2_empty", 32'(EMPTY), 32'd0);
    check("k2_rdata", 32'(RDATA), 32'hA5A5);
    RE = 1'b1;
    tick();
    RE = 1'b0;
    check("k3_empty", 32'(EMPTY), 32'd1);
    check("k3_count", 32'(COUNT), 32'd0);

    // fill to full, then overflow with a pop in the same cycle
    for (int i = 0; i < DEPTH; i++) begin
      WE = 1'b1; WDATA = 16'(i);
      tick();
      if (i == 250)
        check("af_251", 32'(ALMOST_FULL), 32'd0);
      if (i == 251)
        check("af_252", 32'(ALMOST_FULL), 32'd1);
    end
    check("fill_full", 32'(FULL), 32'd1);
    check("fill_count", 32'(COUNT), 32'd256);
    WE = 1'b1; RE = 1'b1; WDATA = 16'hBEEF;
    tick();
    WE = 1'b0; RE = 1'b0;
    check("ovf_set", 32'(OVERFLOW), 32'd1);
    check("ovf_count", 32'(COUNT), 32'd255);
    check("ovf_full", 32'(FULL), 32'd0);
    drain();

    // steady stream across pointer wraps
    do_reset();
    for (int i = 0; i < 200; i++) begin
      WE = 1'b1; WDATA = 16'(i);
      tick();
    end
    WE = 1'b0;
    tick();
    check("pre_stream_count", 32'(COUNT), 32'd200);
    for (int i = 0; i < 600; i++) begin
      WE = 1'b1; RE = 1'b1; WDATA = 16'(200 + i);
      tick();
      if (COUNT != 200)
        check("stream_count", 32'(COUNT), 32'd200);
    end
    check("stream_count_end", 32'(COUNT), 32'd200);
    drain();

    // underflow and almost-empty during refill
    do_reset();
    RE = 1'b1;
    tick();
    RE = 1'b0;
    check("unf_set", 32'(UNDERFLOW), 32'd1);
    check("unf_count", 32'(COUNT), 32'd0);
    repeat (3) tick();
    check("unf_sticky", 32'(UNDERFLOW), 32'd1);
    for (int i = 0; i < 5; i++) begin
      WE = 1'b1; WDATA = 16'(16'h100 + i);
      tick();
      if (i == 3)
        check("ae_at_4", 32'(ALMOST_EMPTY), 32'd1);
    end
    WE = 1'b0;
    check("ae_at_5", 32'(ALMOST_EMPTY), 32'd0);
    check("unf_still", 32'(UNDERFLOW), 32'd1);
    drain();

    // reset mid-stream
    do_reset();
    for (int i = 0; i < 37; i++) begin
      WE = 1'b1; WDATA = 16'(16'h7000 + i);
      tick();
    end
    WE = 1'b1; RE = 1'b1; WDATA = 16'h5555;
    tick();
    check("mid_count", 32'(COUNT), 32'd37);
    RST = 1'b1;
    tick();
    RST = 1'b0; WE = 1'b0; RE = 1'b0;
    check("mrst_count", 32'(COUNT), 32'd0);
    check("mrst_empty", 32'(EMPTY), 32'd1);
    check("mrst_rdata", 32'(RDATA), 32'd0);
    check("mrst_ovf", 32'(OVERFLOW), 32'd0);
    WE = 1'b1; WDATA = 16'h0001;
    tick();
    WE = 1'b0;
    tick();
    check("post_empty", 32'(EMPTY), 32'd0);
    check("post_rdata", 32'(RDATA), 32'h0001);
    drain();
    tick();
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
